// File: rtl/round_robin_packet_mux_2.sv
// round_robin_packet_mux_2: two-source round-robin, packet-aware stream mux with a registered output
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in0_valid/data/last, in0_ready    source 0 beat stream
//   in1_valid/data/last, in1_ready    source 1 beat stream
//   out_valid/data/last/src           registered output beat and the source that produced it
//   out_ready                         consumer accepts the output beat
module round_robin_packet_mux_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_src;
    logic             r_prio;
    logic             r_locked;
    logic             r_lock_src;
    logic             w_load;
    logic             w_win_ok;
    logic             w_win;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic             w_last;
    assign w_load = !r_out_valid || out_ready;
    // A held lock keeps its source eligible even while that source is idle,
    // so the other source cannot slip a beat into the middle of a packet.
    always_comb begin
        w_win_ok = r_locked || in0_valid || in1_valid;
        w_win    = r_locked ? r_lock_src : (in0_valid && in1_valid) ? r_prio : in1_valid;
    end
    assign in0_ready = !rst && w_load && w_win_ok && !w_win;
    assign in1_ready = !rst && w_load && w_win_ok && w_win;
    assign w_xfer    = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign w_data    = w_win ? in1_data : in0_data;
    assign w_last    = w_win ? in1_last : in0_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= 1'b0;
            r_prio      <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_src  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_last  <= w_last;
            r_out_src   <= w_win;
            r_locked    <= !w_last;
            if (w_last) r_prio <= !w_win;
            else r_lock_src <= w_win;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
endmodule

// File: tb/tb_round_robin_packet_mux_2.sv
// tb_round_robin_packet_mux_2: scoreboard bench for the two-source round-robin packet mux
module tb_round_robin_packet_mux_2;
    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } beat_t;
    logic       clk;
    logic       rst;
    logic       in0_valid;
    logic [7:0] in0_data;
    logic       in0_last;
    logic       in0_ready;
    logic       in1_valid;
    logic [7:0] in1_data;
    logic       in1_last;
    logic       in1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_src;
    logic       out_ready;
    beat_t      q0[$];
    beat_t      q1[$];
    logic [9:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    round_robin_packet_mux_2 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic push_exp(input logic src, input logic last, input logic [7:0] data);
        exp_q.push_back({src, last, data});
    endtask
    task automatic wait_empty(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !in0_valid && !in1_valid) break;
        end
        if (i == 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drain: %0d beats still expected", name, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask
    // source 0 driver: holds each beat until the handshake completes
    initial begin
        beat_t b;
        logic  took;
        in0_valid = 1'b0;
        in0_data  = '0;
        in0_last  = 1'b0;
        forever begin
            if (q0.size() == 0) begin
                @(posedge clk);
                #1;
            end else begin
                b = q0.pop_front();
                repeat (b.gap) begin
                    in0_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                in0_valid = 1'b1;
                in0_data  = b.data;
                in0_last  = b.last;
                do begin
                    @(negedge clk);
                    took = in0_ready;
                    @(posedge clk);
                    #1;
                end while (!took);
                in0_valid = 1'b0;
            end
        end
    end
    // source 1 driver
    initial begin
        beat_t b;
        logic  took;
        in1_valid = 1'b0;
        in1_data  = '0;
        in1_last  = 1'b0;
        forever begin
            if (q1.size() == 0) begin
                @(posedge clk);
                #1;
            end else begin
                b = q1.pop_front();
                repeat (b.gap) begin
                    in1_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                in1_valid = 1'b1;
                in1_data  = b.data;
                in1_last  = b.last;
                do begin
                    @(negedge clk);
                    took = in1_ready;
                    @(posedge clk);
                    #1;
                end while (!took);
                in1_valid = 1'b0;
            end
        end
    end
    // monitor: every beat drained by the consumer is checked against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_beat: unexpected beat src=%0d last=%0d data=%h", out_src, out_last, out_data);
            end else begin
                chk("out_beat", {22'd0, out_src, out_last, out_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end
    initial begin
        int i;
        rst       = 1'b1;
        out_ready = 1'b0;
        // reset and idle
        @(negedge clk);
        chk("reset_out", {28'd0, out_valid, out_last, out_src, |out_data}, 32'd0);
        chk("reset_ready", {30'd0, in0_ready, in1_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        // single-beat tie alternation
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            q0.push_back('{8'hA0 + 8'(k), 1'b1, 0});
            q1.push_back('{8'hB0 + 8'(k), 1'b1, 0});
            push_exp(1'b0, 1'b1, 8'hA0 + 8'(k));
            push_exp(1'b1, 1'b1, 8'hB0 + 8'(k));
        end
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in0_valid && in0_ready) break;
        end
        @(negedge clk);
        chk("tie_first_latency", {22'd0, out_valid, out_src, out_data}, {22'd0, 1'b1, 1'b0, 8'hA0});
        wait_empty("tie");
        // solo traffic
        @(posedge clk);
        #1;
        q1.push_back('{8'h11, 1'b1, 0});
        q1.push_back('{8'h22, 1'b1, 1});
        q0.push_back('{8'h33, 1'b1, 4});
        push_exp(1'b1, 1'b1, 8'h11);
        push_exp(1'b1, 1'b1, 8'h22);
        push_exp(1'b0, 1'b1, 8'h33);
        wait_empty("solo");
        // packet lock with a valid gap; in1 waits throughout
        @(posedge clk);
        #1;
        q0.push_back('{8'h01, 1'b0, 0});
        q0.push_back('{8'h02, 1'b0, 0});
        q0.push_back('{8'h03, 1'b1, 1});
        q1.push_back('{8'hF0, 1'b1, 1});
        push_exp(1'b0, 1'b0, 8'h01);
        push_exp(1'b0, 1'b0, 8'h02);
        push_exp(1'b0, 1'b1, 8'h03);
        push_exp(1'b1, 1'b1, 8'hF0);
        begin
            int viol;
            viol = 0;
            for (i = 0; i < 30; i++) begin
                @(negedge clk);
                if (in1_ready) viol++;
                if (in0_valid && in0_ready && in0_last) break;
            end
            chk("lock_in1_ready_cycles", 32'(viol), 32'd0);
        end
        wait_empty("lock");
        // backpressure
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        q0.push_back('{8'hC0, 1'b1, 0});
        q1.push_back('{8'hD0, 1'b1, 0});
        push_exp(1'b0, 1'b1, 8'hC0);
        push_exp(1'b1, 1'b1, 8'hD0);
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int k = 0; k < 4; k++) begin
            chk("backpressure_hold", {19'd0, out_valid, out_src, out_last, out_data, in0_ready, in1_ready, in1_valid},
                {19'd0, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_empty("backpressure");
        // reset mid-packet: E0 from in0 leaves prio=1, then in1 packet is cut by reset
        @(posedge clk);
        #1;
        q0.push_back('{8'hE0, 1'b1, 0});
        push_exp(1'b0, 1'b1, 8'hE0);
        wait_empty("prio_setup");
        @(posedge clk);
        #1;
        q1.push_back('{8'h31, 1'b0, 0});
        q1.push_back('{8'h32, 1'b0, 0});
        q1.push_back('{8'h33, 1'b1, 0});
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in1_valid && in1_ready && in1_data == 8'h31) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.push_back('{8'h77, 1'b1, 0});
        push_exp(1'b0, 1'b1, 8'h77);
        push_exp(1'b1, 1'b0, 8'h32);
        push_exp(1'b1, 1'b1, 8'h33);
        @(negedge clk);
        chk("midreset_ready", {30'd0, in0_ready, in1_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midreset_ready2", {29'd0, in1_valid, in0_ready, in1_ready}, {29'd0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_state", {28'd0, out_valid, in0_valid, in0_ready, in1_ready}, {28'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        wait_empty("midreset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
